// File: rtl/fix2flt_pkg.sv
// rtl/fix2flt_pkg.sv - state encoding and format helpers shared by fix2flt_seq and flt_pack
package fix2flt_pkg;

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_e;

  localparam int DEF_INT_W  = 8;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_EXP_W  = 5;
  localparam int DEF_MAN_W  = 10;

  function automatic int fix_w(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

  function automatic int flt_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/flt_pack.sv
// rtl/flt_pack.sv - combinational exponent/mantissa packing with flush and saturation
// Optional round-to-nearest-even when FIX2FLT_ROUND_NE_EN is defined.
module flt_pack
  import fix2flt_pkg::*;
#(
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MAN_W  = DEF_MAN_W,
  parameter int W      = 16,
  parameter int PW     = 4,
  localparam int F     = flt_w(EXP_W, MAN_W)
) (
  input  logic          sign_i,
  input  logic [W-1:0]  mag_i,
  input  logic [PW-1:0] pos_i,
  output logic [F-1:0]  flt_o
);

  localparam int BIAS    = bias(EXP_W);
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  // Bits below the hidden one, left-aligned; extra zero padding covers W-1 < MAN_W.
  logic [W+MAN_W-1:0] aligned;
  logic [MAN_W-1:0]   man_trunc;
  logic [MAN_W-1:0]   man_v;
  logic               unused_bits;
  int                 exp_v;

  assign aligned   = {mag_i[W-2:0], {(MAN_W+1){1'b0}}};
  assign man_trunc = aligned[W+MAN_W-1 -: MAN_W];

`ifdef FIX2FLT_ROUND_NE_EN
  logic           guard;
  logic           sticky;
  logic           round_up;
  logic [MAN_W:0] man_sum;

  assign guard       = aligned[W-1];
  assign sticky      = |aligned[W-2:0];
  assign round_up    = guard & (sticky | man_trunc[0]);
  assign man_sum     = {1'b0, man_trunc} + {{MAN_W{1'b0}}, round_up};
  assign unused_bits = mag_i[W-1];
`else
  assign unused_bits = ^{mag_i[W-1], aligned[W-1:0]};
`endif

  always_comb begin
    exp_v = int'(pos_i) - FRAC_W + BIAS;
    man_v = man_trunc;
`ifdef FIX2FLT_ROUND_NE_EN
    if (man_sum[MAN_W]) begin
      man_v = '0;
      exp_v = exp_v + 1;
    end else begin
      man_v = man_sum[MAN_W-1:0];
    end
`endif
    flt_o = '0;
    if (mag_i == '0) begin
      flt_o = '0;
    end else if (exp_v <= 0) begin
      flt_o = {sign_i, {(F-1){1'b0}}};
    end else if (exp_v >= EXP_MAX) begin
      flt_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      flt_o = {sign_i, exp_v[EXP_W-1:0], man_v};
    end
  end

endmodule

// File: rtl/fix2flt_seq.sv
// rtl/fix2flt_seq.sv - sequential fixed-to-float converter, one normalising shift per cycle
// Rounding mode selected by FIX2FLT_ROUND_NE_EN (see flt_pack).
module fix2flt_seq
  import fix2flt_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MAN_W  = DEF_MAN_W,
  localparam int W     = fix_w(INT_W, FRAC_W),
  localparam int F     = flt_w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] fix_in,
  output logic         busy,
  output logic         done,
  output logic [F-1:0] flt_out
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;

  if (W < 2 || MAN_W < 1 || EXP_W < 2) begin : g_bad_params
    $error("fix2flt_seq: need W>=2, MAN_W>=1, EXP_W>=2");
  end

  state_e        state_q, state_d;
  logic          sign_q, sign_d;
  logic [W-1:0]  mag_q, mag_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [F-1:0]  flt_q, flt_d;
  logic          done_q, done_d;
  logic [F-1:0]  pack_flt;

  flt_pack #(
    .FRAC_W (FRAC_W),
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .W      (W),
    .PW     (PW)
  ) u_pack (
    .sign_i (sign_q),
    .mag_i  (mag_q),
    .pos_i  (pos_q),
    .flt_o  (pack_flt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      pos_q   <= '0;
      flt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      pos_q   <= pos_d;
      flt_q   <= flt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    pos_d   = pos_q;
    flt_d   = flt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = fix_in[W-1];
          mag_d   = fix_in[W-1] ? -fix_in : fix_in;
          pos_d   = PW'(W - 1);
          state_d = NORM;
        end
      end
      NORM: begin
        // Zero never normalises, so it leaves after a single cycle.
        if (mag_q == '0 || mag_q[W-1]) begin
          state_d = PACK;
        end else begin
          mag_d = {mag_q[W-2:0], 1'b0};
          pos_d = pos_q - PW'(1);
        end
      end
      PACK: begin
        flt_d   = pack_flt;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE) || done_q;
  assign done    = done_q;
  assign flt_out = flt_q;

endmodule

// File: tb/tb_fix2flt_seq.sv
// tb/tb_fix2flt_seq.sv - scoreboard bench for fix2flt_seq in three formats
module tb_fix2flt_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, start2;
  logic [15:0] fix0, fix1, fix2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [15:0] flt0, flt1;
  logic [7:0]  flt2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  typedef struct {
    logic [15:0] flt;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  fix2flt_seq u_dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .fix_in(fix0),
    .busy(busy0), .done(done0), .flt_out(flt0)
  );

  fix2flt_seq #(.INT_W(16), .FRAC_W(0), .EXP_W(5), .MAN_W(10)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .fix_in(fix1),
    .busy(busy1), .done(done1), .flt_out(flt1)
  );

  fix2flt_seq #(.INT_W(6), .FRAC_W(10), .EXP_W(3), .MAN_W(4)) u_dut2 (
    .clk(clk), .reset(rst_n), .start(start2), .fix_in(fix2),
    .busy(busy2), .done(done2), .flt_out(flt2)
  );

  // Arithmetic reference: exact quotient/remainder instead of bit slicing.
  function automatic void model(input logic [15:0] v, input int frac_w, input int exp_w,
                                input int man_w, output logic [15:0] flt, output int lat);
    longint mag, rem, scaled, man, r, half, res, s;
    int p, e;
    s   = longint'(v[15]);
    mag = v[15] ? (65536 - longint'(v)) : longint'(v);
    if (mag == 0) begin
      flt = '0;
      lat = 2;
      return;
    end
    p = 15;
    while (((mag >> p) & 1) == 0) p--;
    lat    = 2 + 15 - p;
    e      = p - frac_w + (1 << (exp_w - 1)) - 1;
    rem    = mag - (longint'(1) << p);
    scaled = rem << man_w;
    man    = scaled >> p;
    r      = scaled - (man << p);
`ifdef FIX2FLT_ROUND_NE_EN
    if (p > 0) begin
      half = longint'(1) << (p - 1);
      if (r > half || (r == half && (man & 1) == 1)) man = man + 1;
    end
    if (man == (longint'(1) << man_w)) begin
      man = 0;
      e   = e + 1;
    end
`else
    half = r;
`endif
    if (e <= 0)
      res = s << (exp_w + man_w);
    else if (e >= (1 << exp_w) - 1)
      res = (s << (exp_w + man_w)) | (((longint'(1) << exp_w) - 1) << man_w);
    else
      res = (s << (exp_w + man_w)) | (longint'(e) << man_w) | man;
    flt = res[15:0];
  endfunction

  task automatic expect_for(input int d, input logic [15:0] v,
                            output logic [15:0] f, output int lat);
    case (d)
      0:       model(v, 8, 5, 10, f, lat);
      1:       model(v, 0, 5, 10, f, lat);
      default: model(v, 10, 3, 4, f, lat);
    endcase
  endtask

  task automatic drive(input int d, input logic s, input logic [15:0] v);
    case (d)
      0:       begin start0 = s; fix0 = v; end
      1:       begin start1 = s; fix1 = v; end
      default: begin start2 = s; fix2 = v; end
    endcase
  endtask

  function automatic logic get_done(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic [15:0] get_flt(input int d);
    case (d)
      0:       return flt0;
      1:       return flt1;
      default: return {8'h00, flt2};
    endcase
  endfunction

  task automatic wait_done(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (get_done(d)) ok = 1'b1;
    end
  endtask

  task automatic check_pop(input int d, input bit ok, input int t0);
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen within 64 cycles, want latency %0d", e.name, e.lat);
    end else begin
      if (get_flt(d) !== e.flt) begin
        n_fail++;
        $display("FAIL %s flt_out: got %h want %h", e.name, get_flt(d), e.flt);
      end
      n_checks++;
      if (cyc_cnt - t0 !== e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", e.name, cyc_cnt - t0, e.lat);
      end
    end
  endtask

  // Caller positions this away from the edge; start is sampled on the next rising edge.
  task automatic launch(input int d, input logic [15:0] v, input logic [15:0] want, input string name);
    exp_t e;
    logic [15:0] mf;
    int ml, t0;
    bit ok;
    expect_for(d, v, mf, ml);
    e.flt = want; e.lat = ml; e.name = name;
    drive(d, 1'b1, v);
    sb.push_back(e);
    @(posedge clk);
    #1;
    t0 = cyc_cnt;
    drive(d, 1'b0, v);
    wait_done(d, ok);
    check_pop(d, ok, t0);
  endtask

  task automatic run(input int d, input logic [15:0] v, input logic [15:0] want, input string name);
    @(negedge clk);
    launch(d, v, want, name);
  endtask

  task automatic run_model(input int d, input logic [15:0] v, input string name);
    logic [15:0] mf;
    int ml;
    expect_for(d, v, mf, ml);
    run(d, v, mf, name);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0); drive(1, 1'b0, 16'h0); drive(2, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy0); end
    n_checks++;
    if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done0); end
    n_checks++;
    if (flt0 !== 16'h0) begin n_fail++; $display("FAIL reset flt_out: got %h want 0000", flt0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run(0, 16'h0001, 16'h1C00, "dir_0001");
    run(0, 16'hFFFF, 16'h9C00, "dir_FFFF");
    run(0, 16'h0030, 16'h3200, "dir_0030");
    run(0, 16'h8000, 16'hD800, "dir_8000");
    run(0, 16'h0000, 16'h0000, "dir_0000");
`ifdef FIX2FLT_ROUND_NE_EN
    run(0, 16'h7FFF, 16'h5800, "dir_7FFF_rne");
`else
    run(0, 16'h7FFF, 16'h57FF, "dir_7FFF_trunc");
`endif
  endtask

  task automatic test_params;
`ifdef FIX2FLT_ROUND_NE_EN
    run(1, 16'h7FFF, 16'h7800, "p16_7FFF_rne");
    run(2, 16'h3FFF, 16'h0070, "p6_3FFF_round_to_inf");
`else
    run(1, 16'h7FFF, 16'h77FF, "p16_7FFF_trunc");
    run(2, 16'h3FFF, 16'h006F, "p6_3FFF_trunc");
`endif
    run(1, 16'h8000, 16'hF800, "p16_8000");
    run(2, 16'h0001, 16'h0000, "p6_flush_pos");
    run(2, 16'hFFFF, 16'h0080, "p6_flush_neg");
    run(2, 16'h7FFF, 16'h0070, "p6_inf_pos");
    run(2, 16'h8000, 16'h00F0, "p6_inf_neg");
    run(2, 16'h2000, 16'h0060, "p6_normal");
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    int t0, extra;
    bit ok;
    @(negedge clk);
    drive(0, 1'b1, 16'h0001);
    e.flt = 16'h1C00; e.lat = 17; e.name = "busy_ignore";
    sb.push_back(e);
    @(posedge clk);
    #1;
    t0 = cyc_cnt;
    drive(0, 1'b0, 16'h0001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL busy_during_norm: got %b want 1", busy0); end
    drive(0, 1'b1, 16'h0030);
    @(negedge clk);
    drive(0, 1'b0, 16'h0030);
    wait_done(0, ok);
    check_pop(0, ok, t0);
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done0) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL busy_ignore_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back;
    run(0, 16'h0030, 16'h3200, "b2b_first");
    n_checks++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_in_done: got %b want 1", busy0); end
    launch(0, 16'h8000, 16'hD800, "b2b_second");
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    drive(0, 1'b1, 16'h0003);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 16'h0003);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b want 0", busy0); end
    n_checks++;
    if (done0 !== 1'b0) begin n_fail++; $display("FAIL abort done: got %b want 0", done0); end
    n_checks++;
    if (flt0 !== 16'h0) begin n_fail++; $display("FAIL abort flt_out: got %h want 0000", flt0); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    run(0, 16'h0030, 16'h3200, "after_abort");
  endtask

  task automatic test_random_sweep;
    logic [15:0] v;
    for (int i = 0; i < 200; i++) begin
      v = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = -v;
      run_model(0, v, "rand_q8_8");
    end
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = -v;
      run_model(2, v, "rand_q6_10");
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_params();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
